alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester valid/ready arbiter sharing one 4-bit ALU
// Define ALU_ARBITER_RR_EN for round-robin arbitration; default build is fixed priority (req0 wins).

module alu4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [2:0] i_op,
  output logic [7:0] o_y
);
  always_comb begin
    o_y = 8'h00;
    case (i_op)
      3'd0:    o_y = {4'h0, i_a | i_b};
      3'd1:    o_y = {4'h0, i_a ^ i_b};
      3'd2:    o_y = {4'h0, i_a & i_b};
      3'd3:    o_y = {4'h0, i_a} + {4'h0, i_b};
      3'd4:    o_y = {4'h0, i_a} - {4'h0, i_b};
      3'd5:    o_y = {4'h0, i_a} * {4'h0, i_b};
      default: o_y = 8'h00;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_op;
  logic       r_id;
  logic [3:0] r_cnt;
  logic       r_rsp_valid;
  logic       r_rsp_id;
  logic [7:0] r_rsp_data;
  logic       w_grant_id;
  logic       w_r0_ready;
  logic       w_r1_ready;
  logic       w_accept;
  logic       w_exec_done;
  logic [7:0] w_alu_y;
  logic [2:0] w_sel_op;

`ifdef ALU_ARBITER_RR_EN
  logic r_last_grant;

  // On a conflict the requester that was not served last wins.
  always_comb begin
    w_grant_id = 1'b0;
    if (req0_valid && req1_valid) w_grant_id = ~r_last_grant;
    else                          w_grant_id = req1_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_grant <= 1'b1;
    else if (w_accept) r_last_grant <= w_grant_id;
  end
`else
  always_comb begin
    w_grant_id = 1'b0;
    if (!req0_valid) w_grant_id = req1_valid;
  end
`endif

  assign w_exec_done = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_sel_op    = w_grant_id ? req1_op : req0_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_r0_ready = 1'b0;
    w_r1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_r0_ready = req0_valid && !w_grant_id;
        w_r1_ready = req1_valid &&  w_grant_id;
        if (w_r0_ready || w_r1_ready) w_next = S_EXEC;
      end
      S_EXEC: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = w_r0_ready || w_r1_ready;

  // Readies are forced low during reset even though the state already reads IDLE.
  assign req0_ready = w_r0_ready && rst_n;
  assign req1_ready = w_r1_ready && rst_n;

  alu4 u_alu (
    .i_a  (r_a),
    .i_b  (r_b),
    .i_op (r_op),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= 4'h0;
      r_b         <= 4'h0;
      r_op        <= 3'd0;
      r_id        <= 1'b0;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      if (w_accept) begin
        r_a   <= w_grant_id ? req1_a : req0_a;
        r_b   <= w_grant_id ? req1_b : req0_b;
        r_op  <= w_sel_op;
        r_id  <= w_grant_id;
        r_cnt <= (w_sel_op == 3'd5) ? 4'(MUL_LAT - 1) : 4'd0;
      end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_exec_done) begin
        r_rsp_data  <= w_alu_y;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
      end else if (r_rsp_valid && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a transaction model

module tb_alu_arbiter;
  localparam int MUL_LAT = 3;
`ifdef ALU_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       r0v = 1'b0, r1v = 1'b0;
  logic [3:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic [2:0] r0op = '0, r1op = '0;
  logic       rsp_ready = 1'b1;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0] rsp_data;

  int n_tests = 0, n_fail = 0, cyc = 0;
  bit m_busy = 0, m_last = 1, rsp_seen = 1;
  int m_rsp_cyc = 0, m_id = 0, m_acc = 0;
  logic [7:0] m_data = '0;
  int acc_cyc = 0, first_rsp_cyc = 0, obs_acc = 0, obs_acc_cyc = 0, hs_cyc = 0;
  int obs_grants[$];
  logic [7:0] obs_data[$];

  alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_ready(req0_ready), .req0_a(r0a), .req0_b(r0b), .req0_op(r0op),
    .req1_valid(r1v), .req1_ready(req1_ready), .req1_a(r1a), .req1_b(r1b), .req1_op(r1op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] alu_ref(input int a, input int b, input int op);
    int x;
    case (op)
      0: x = a | b;
      1: x = a ^ b;
      2: x = a & b;
      3: x = a + b;
      4: x = a - b;
      5: x = a * b;
      default: x = 0;
    endcase
    return 8'(x);
  endfunction

  // One cycle: check outputs at the falling edge, advance the model for the coming rising edge.
  task automatic step();
    int g;
    bit exp_v;
    @(negedge clk);
    g = -1;
    if (!m_busy) begin
      if (r0v && r1v) g = RR ? (m_last ? 0 : 1) : 0;
      else if (r0v)   g = 0;
      else if (r1v)   g = 1;
    end
    chk("req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("req1_ready", 32'(req1_ready), 32'(g == 1));
    exp_v = m_busy && (cyc >= m_rsp_cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      chk("rsp_data", 32'(rsp_data), 32'(m_data));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    if (m_busy && rsp_valid && !rsp_seen) begin
      rsp_seen      = 1;
      first_rsp_cyc = cyc;
    end
    if (r0v && req0_ready) begin obs_grants.push_back(0); obs_acc++; obs_acc_cyc = cyc; end
    if (r1v && req1_ready) begin obs_grants.push_back(1); obs_acc++; obs_acc_cyc = cyc; end
    if (rsp_valid && rsp_ready) begin obs_data.push_back(rsp_data); hs_cyc = cyc; end
    if (exp_v && rsp_ready) begin
      m_busy = 0;
    end else if (g >= 0) begin
      m_busy    = 1;
      m_id      = g;
      m_data    = (g == 0) ? alu_ref(int'(r0a), int'(r0b), int'(r0op))
                           : alu_ref(int'(r1a), int'(r1b), int'(r1op));
      m_rsp_cyc = cyc + (((g == 0 ? r0op : r1op) == 3'd5) ? MUL_LAT : 1) + 1;
      m_last    = (g == 1);
      m_acc++;
      acc_cyc   = cyc;
      rsp_seen  = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_busy && k < 60) begin step(); k++; end
    chk("drain_done", 32'(m_busy), 32'd0);
  endtask

  task automatic run_op(input int who, input int a, input int b, input int op);
    int start = m_acc;
    int k = 0;
    if (who == 0) begin r0a = 4'(a); r0b = 4'(b); r0op = 3'(op); r0v = 1; end
    else          begin r1a = 4'(a); r1b = 4'(b); r1op = 3'(op); r1v = 1; end
    while (m_acc == start && k < 40) begin step(); k++; end
    chk("accept_seen", 32'(m_acc != start), 32'd1);
    r0v = 0;
    r1v = 0;
    wait_idle();
  endtask

  initial begin
    int rel_cyc, start, k, n, acc_before;
    logic [7:0] hold_data;
    logic hold_id;

    // Reset state, with a request already pending.
    r0v = 1;
    #12;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1;
    rel_cyc = cyc;

    // OR 15|13 from req0; accept in the first cycle after release.
    run_op(0, 15, 13, 0);
    chk("first_accept_cycle", 32'(obs_acc_cyc - rel_cyc), 32'd0);
    chk("or_latency", 32'(first_rsp_cyc - acc_cyc), 32'd2);
    chk("or_data", 32'(obs_data[$]), 32'h0F);

    // MUL 14*7 from req1 with MUL_LAT=3.
    run_op(1, 14, 7, 5);
    chk("mul_latency", 32'(first_rsp_cyc - acc_cyc), 32'd4);
    chk("mul_data", 32'(obs_data[$]), 32'h62);

    // Both requesters continuously valid, four ADD 12+15.
    r0a = 12; r0b = 15; r0op = 3; r1a = 12; r1b = 15; r1op = 3;
    r0v = 1; r1v = 1;
    start = obs_acc;
    k = 0;
    while (obs_acc < start + 4 && k < 80) begin step(); k++; end
    r0v = 0; r1v = 0;
    wait_idle();
    n = obs_grants.size();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("conflict_grant%0d", i), 32'(obs_grants[n-4+i]), RR ? 32'(i % 2) : 32'd0);
      chk($sformatf("conflict_data%0d", i), 32'(obs_data[obs_data.size()-4+i]), 32'h1B);
    end

    // Back-pressure: response held 5 cycles while req1 waits.
    rsp_ready = 0;
    r0a = 10; r0b = 6; r0op = 1; r0v = 1;
    r1a = 3; r1b = 4; r1op = 3; r1v = 1;
    start = obs_acc;
    k = 0;
    while (obs_acc == start && k < 20) begin step(); k++; end
    r0v = 0;
    k = 0;
    while (!rsp_seen && k < 20) begin step(); k++; end
    hold_data = rsp_data;
    hold_id = rsp_id;
    acc_before = obs_acc;
    repeat (5) begin
      step();
      chk("hold_data", 32'(rsp_data), 32'(hold_data));
      chk("hold_id", 32'(rsp_id), 32'(hold_id));
    end
    chk("no_second_accept", 32'(obs_acc), 32'(acc_before));
    rsp_ready = 1;
    k = 0;
    while (obs_acc == acc_before && k < 20) begin step(); k++; end
    r1v = 0;
    chk("reaccept_gap", 32'(obs_acc_cyc - hs_cyc), 32'd1);
    chk("reaccept_id", 32'(obs_grants[$]), 32'd1);
    wait_idle();
    chk("hold_result", 32'(obs_data[obs_data.size()-2]), 32'h0C);

    // Unused opcode.
    run_op(0, 5, 8, 6);
    chk("op6_latency", 32'(first_rsp_cyc - acc_cyc), 32'd2);
    chk("op6_data", 32'(obs_data[$]), 32'h00);

    // Reset pulsed during MUL execution.
    r1a = 9; r1b = 11; r1op = 5; r1v = 1;
    start = m_acc;
    k = 0;
    while (m_acc == start && k < 20) begin step(); k++; end
    r1v = 0;
    r0v = 1;
    #2;
    rst_n = 0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_req0_ready", 32'(req0_ready), 32'd0);
    chk("abort_rsp_data", 32'(rsp_data), 32'd0);
    m_busy = 0;
    m_last = 1;
    rsp_seen = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    r0v = 0;
    n = obs_data.size();
    repeat (8) step();
    chk("no_rsp_after_abort", 32'(obs_data.size()), 32'(n));
    run_op(0, 9, 11, 5);
    chk("post_reset_latency", 32'(first_rsp_cyc - acc_cyc), 32'd4);
    chk("post_reset_data", 32'(obs_data[$]), 32'h63);

    // Randomized traffic against the model.
    start = obs_data.size();
    for (int i = 0; i < 600; i++) begin
      r0v = 1'($urandom_range(0, 1));
      r1v = 1'($urandom_range(0, 1));
      r0a = 4'($urandom); r0b = 4'($urandom); r0op = 3'($urandom);
      r1a = 4'($urandom); r1b = 4'($urandom); r1op = 3'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    r0v = 0; r1v = 0; rsp_ready = 1;
    wait_idle();
    chk("random_traffic_flowed", 32'(obs_data.size() > start + 20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
